// File: rtl/accel_run_sequencer_pkg.sv
// Shared types and default sizing for the accelerator run sequencer.
package accel_run_sequencer_pkg;

  localparam int DEF_ADDR_W         = 7;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_SIZE_W         = 4;
  localparam int DEF_TIMEOUT_CYCLES = 200000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_READ_OUT,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/accel_run_sequencer_if.sv
// Two-channel slave RAM bus between the sequencer (master) and the accelerator memory (slave).
interface accel_run_sequencer_if
  import accel_run_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SIZE_W = DEF_SIZE_W
) ();

  logic [1:0]          S_oe_ram;
  logic [1:0]          S_we_ram;
  logic [2*ADDR_W-1:0] S_addr_ram;
  logic [2*DATA_W-1:0] S_Wdata_ram;
  logic [2*SIZE_W-1:0] S_data_ram_size;
  logic [2*DATA_W-1:0] Sout_Rdata_ram;
  logic [1:0]          Sout_DataRdy;

  modport master (
    output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    input  Sout_Rdata_ram, Sout_DataRdy
  );

  modport slave (
    input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy
  );

endinterface

// File: rtl/accel_slave_port.sv
// Channel-0 slave bus encoder and read-data capture register; channel 1 is held at zero.
module accel_slave_port
  import accel_run_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic              i_cap,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rdy,
  output logic [DATA_W-1:0] o_rdata,
  accel_run_sequencer_if.master bus
);

  logic              w_act;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [SIZE_W-1:0] w_size;
  logic [DATA_W-1:0] r_rdata;
  logic              w_unused_hi;

  // Address and size are only presented during an access so the bus idles at zero.
  assign w_act   = i_wr | i_rd;
  assign w_addr  = w_act ? i_addr : '0;
  assign w_wdata = i_wr ? i_wdata : '0;
  assign w_size  = w_act ? SIZE_W'(DATA_W) : '0;

  assign bus.S_we_ram        = {1'b0, i_wr};
  assign bus.S_oe_ram        = {1'b0, i_rd};
  assign bus.S_addr_ram      = {{ADDR_W{1'b0}}, w_addr};
  assign bus.S_Wdata_ram     = {{DATA_W{1'b0}}, w_wdata};
  assign bus.S_data_ram_size = {{SIZE_W{1'b0}}, w_size};

  assign o_rdy       = bus.Sout_DataRdy[0];
  assign w_unused_hi = ^{bus.Sout_Rdata_ram[2*DATA_W-1:DATA_W], bus.Sout_DataRdy[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_cap && bus.Sout_DataRdy[0]) begin
      r_rdata <= bus.Sout_Rdata_ram[DATA_W-1:0];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/accel_run_sequencer.sv
// Load -> start -> run -> readback sequencer for an accelerator behind a slave RAM bus.
// Optional run-phase watchdog enabled by defining SEQ_TIMEOUT_EN.
module accel_run_sequencer
  import accel_run_sequencer_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int SIZE_W         = DEF_SIZE_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_go,
  input  logic [ADDR_W-1:0] i_load_base,
  input  logic [ADDR_W-1:0] i_rd_base,
  input  logic [ADDR_W:0]   i_load_len,
  input  logic [ADDR_W:0]   i_rd_len,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_rb_valid,
  input  logic              i_rb_ready,
  output logic [DATA_W-1:0] o_rb_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_start_port,
  input  logic              i_done_port,
  accel_run_sequencer_if.master bus
);

  localparam logic [ADDR_W:0] ONE_LEN = 1;

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rd_base;
  logic [ADDR_W:0]   r_ld_cnt;
  logic [ADDR_W:0]   r_rd_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_start;
  logic              r_ld_ready;
  logic              r_rb_valid;
  logic              r_oe;
  logic              w_wr;
  logic              w_cap;
  logic              w_rdy;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  assign w_wr  = r_ld_ready & i_ld_valid;
  assign w_cap = (r_state == ST_READ_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rd_base  <= '0;
      r_ld_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_start    <= 1'b0;
      r_ld_ready <= 1'b0;
      r_rb_valid <= 1'b0;
      r_oe       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_go) begin
            r_addr    <= i_load_base;
            r_rd_base <= i_rd_base;
            r_ld_cnt  <= i_load_len;
            r_rd_cnt  <= i_rd_len;
            r_busy    <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (i_load_len != '0) begin
              r_state    <= ST_LOAD;
              r_ld_ready <= 1'b1;
            end else begin
              r_state <= ST_START;
              r_start <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (i_ld_valid) begin
            r_addr   <= r_addr + 1'b1;
            r_ld_cnt <= r_ld_cnt - 1'b1;
            if (r_ld_cnt == ONE_LEN) begin
              r_state    <= ST_START;
              r_ld_ready <= 1'b0;
              r_start    <= 1'b1;
            end
          end
        end
        ST_START: begin
          r_start <= 1'b0;
          r_addr  <= r_rd_base;
          r_state <= ST_RUN;
`ifdef SEQ_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        ST_RUN: begin
          if (i_done_port) begin
            if (r_rd_cnt != '0) begin
              r_state <= ST_READ_REQ;
              r_oe    <= 1'b1;
            end else begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= ST_FINISH;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        ST_READ_REQ: begin
          r_oe    <= 1'b0;
          r_state <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (w_rdy) begin
            r_rb_valid <= 1'b1;
            r_state    <= ST_READ_OUT;
          end
        end
        ST_READ_OUT: begin
          if (i_rb_ready) begin
            r_rb_valid <= 1'b0;
            r_addr     <= r_addr + 1'b1;
            r_rd_cnt   <= r_rd_cnt - 1'b1;
            if (r_rd_cnt == ONE_LEN) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ_REQ;
              r_oe    <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  accel_slave_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W)
  ) u_slave_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_wr),
    .i_rd    (r_oe),
    .i_cap   (w_cap),
    .i_addr  (r_addr),
    .i_wdata (i_ld_data),
    .o_rdy   (w_rdy),
    .o_rdata (o_rb_data),
    .bus     (bus)
  );

  assign o_ld_ready   = r_ld_ready;
  assign o_rb_valid   = r_rb_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_start_port = r_start;
`ifdef SEQ_TIMEOUT_EN
  assign o_timeout    = r_timeout;
`else
  assign o_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_accel_run_sequencer.sv
// Directed bench for accel_run_sequencer; covers timeout behaviour when SEQ_TIMEOUT_EN is defined.
module tb_accel_run_sequencer;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 1000;
`endif

  logic       clk;
  logic       rst_n;
  logic       i_go;
  logic [6:0] i_load_base, i_rd_base;
  logic [7:0] i_load_len, i_rd_len;
  logic       i_ld_valid, o_ld_ready;
  logic [7:0] i_ld_data;
  logic       o_rb_valid, i_rb_ready;
  logic [7:0] o_rb_data;
  logic       o_busy, o_done, o_timeout, o_start_port, i_done_port;

  accel_run_sequencer_if #(.ADDR_W(7), .DATA_W(8), .SIZE_W(4)) bus ();

  accel_run_sequencer #(
    .ADDR_W(7), .DATA_W(8), .SIZE_W(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go),
    .i_load_base(i_load_base), .i_rd_base(i_rd_base),
    .i_load_len(i_load_len), .i_rd_len(i_rd_len),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_data(i_ld_data),
    .o_rb_valid(o_rb_valid), .i_rb_ready(i_rb_ready), .o_rb_data(o_rb_data),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_start_port(o_start_port), .i_done_port(i_done_port),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0, n_bad = 0;
  int unsigned cyc = 0;
  int unsigned wr_cnt = 0, oe_cnt = 0, start_cnt = 0, done_cnt = 0, spur_cnt = 0, ch1_cnt = 0;
  int unsigned start_cyc = 0, done_cyc = 0;
  logic        done_tmo = 1'b0;
  logic [6:0]  wr_addr [64];
  logic [7:0]  wr_data [64];
  logic [3:0]  wr_size [64];
  logic [7:0]  mem [128];
  logic [6:0]  rd_addr [64];
  int unsigned rd_cnt = 0;
  int unsigned rdy_dly = 2;
  logic [7:0]  ld_words [8];
  logic [7:0]  rb_got [8];
  int unsigned b_wr, b_oe, b_start, b_done, b_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus / handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.S_we_ram[0]) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = bus.S_addr_ram[6:0];
        wr_data[wr_cnt] = bus.S_Wdata_ram[7:0];
        wr_size[wr_cnt] = bus.S_data_ram_size[3:0];
      end
      wr_cnt++;
    end
    if (bus.S_oe_ram[0]) oe_cnt++;
    if (!bus.S_we_ram[0] && !bus.S_oe_ram[0] &&
        (bus.S_addr_ram != '0 || bus.S_Wdata_ram != '0 || bus.S_data_ram_size != '0))
      spur_cnt++;
    if (bus.S_we_ram[1] || bus.S_oe_ram[1] || (bus.S_addr_ram[13:7] != '0) ||
        (bus.S_Wdata_ram[15:8] != '0) || (bus.S_data_ram_size[7:4] != '0))
      ch1_cnt++;
    if (o_start_port) begin start_cnt++; start_cyc = cyc; end
    if (o_done) begin done_cnt++; done_cyc = cyc; done_tmo = o_timeout; end
  end

  // Slave RAM responder: returns mem[addr] rdy_dly cycles after a read strobe.
  initial begin
    logic [6:0] a;
    bus.Sout_Rdata_ram = '0;
    bus.Sout_DataRdy   = '0;
    forever begin
      @(negedge clk);
      if (bus.S_oe_ram[0]) begin
        a = bus.S_addr_ram[6:0];
        if (rd_cnt < 64) rd_addr[rd_cnt] = a;
        rd_cnt++;
        repeat (rdy_dly) @(posedge clk);
        #1;
        bus.Sout_Rdata_ram = {8'hEE, mem[a]};
        bus.Sout_DataRdy   = 2'b11;
        @(posedge clk);
        #1;
        bus.Sout_Rdata_ram = '0;
        bus.Sout_DataRdy   = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

  task automatic snap();
    b_wr = wr_cnt; b_oe = oe_cnt; b_start = start_cnt; b_done = done_cnt; b_rd = rd_cnt;
  endtask

  task automatic do_go(input logic [6:0] lb, input logic [6:0] rb, input logic [7:0] ll, input logic [7:0] rl);
    i_load_base = lb; i_rd_base = rb; i_load_len = ll; i_rd_len = rl;
    i_go = 1'b1;
    step();
    i_go = 1'b0;
  endtask

  task automatic feed_load(input int unsigned n);
    int unsigned k = 0, guard = 0;
    bit gap = 1'b1, hs;
    while (k < n && guard < 100) begin
      if (o_ld_ready && !(k == 1 && gap)) begin
        i_ld_valid = 1'b1;
        i_ld_data  = ld_words[k];
      end else begin
        i_ld_valid = 1'b0;
        if (k == 1) gap = 1'b0;
      end
      hs = i_ld_valid && o_ld_ready;
      step();
      if (hs) k++;
      guard++;
    end
    chk("load_words", k, n);
    i_ld_valid = 1'b0;
  endtask

  task automatic wait_start();
    int unsigned g = 0;
    while (!o_start_port && g < 50) begin step(); g++; end
    chk("start_seen", 32'(o_start_port), 1);
  endtask

  task automatic pulse_done(input int unsigned dly);
    repeat (dly) step();
    i_done_port = 1'b1;
    step();
    i_done_port = 1'b0;
  endtask

  task automatic serve_reads(input int unsigned n, input int unsigned hold);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned g = 0;
      logic [7:0] d;
      while (!o_rb_valid && g < 50) begin step(); g++; end
      chk("rbv_seen", 32'(o_rb_valid), 1);
      d = o_rb_data;
      rb_got[k] = d;
      for (int unsigned h = 0; h < hold; h++) begin
        step();
        chk("rb_stable", 32'(o_rb_data), 32'(d));
        chk("rbv_held", 32'(o_rb_valid), 1);
      end
      i_rb_ready = 1'b1;
      step();
      i_rb_ready = 1'b0;
    end
  endtask

  task automatic wait_done();
    int unsigned g = 0;
    while (!o_done && g < 200) begin step(); g++; end
    chk("done_seen", 32'(o_done), 1);
    step();
    chk("busy_clr", 32'(o_busy), 0);
    chk("done_one", 32'(o_done), 0);
  endtask

  initial begin
    rst_n = 1'b0; i_go = 1'b0; i_load_base = '0; i_rd_base = '0;
    i_load_len = '0; i_rd_len = '0; i_ld_valid = 1'b0; i_ld_data = '0;
    i_rb_ready = 1'b0; i_done_port = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    repeat (3) step();

    // reset state
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_tmo", 32'(o_timeout), 0);
    chk("rst_ldr", 32'(o_ld_ready), 0);
    chk("rst_rbv", 32'(o_rb_valid), 0);
    chk("rst_start", 32'(o_start_port), 0);
    chk("rst_we", 32'(bus.S_we_ram), 0);
    chk("rst_oe", 32'(bus.S_oe_ram), 0);
    chk("rst_addr", 32'(bus.S_addr_ram), 0);
    chk("rst_size", 32'(bus.S_data_ram_size), 0);
    rst_n = 1'b1;

    // three-word load wrapping at the top of the address space
    snap();
    ld_words[0] = 8'h11; ld_words[1] = 8'h22; ld_words[2] = 8'h33;
    do_go(7'h7E, 7'h00, 8'd3, 8'd0);
    chk("go_busy", 32'(o_busy), 1);
    chk("go_ldr", 32'(o_ld_ready), 1);
    feed_load(3);
    wait_start();
    pulse_done(2);
    wait_done();
    chk("ld_wr_cnt", wr_cnt - b_wr, 3);
    chk("ld_addr0", 32'(wr_addr[b_wr]), 32'h7E);
    chk("ld_addr1", 32'(wr_addr[b_wr+1]), 32'h7F);
    chk("ld_addr2", 32'(wr_addr[b_wr+2]), 32'h00);
    chk("ld_data0", 32'(wr_data[b_wr]), 32'h11);
    chk("ld_data1", 32'(wr_data[b_wr+1]), 32'h22);
    chk("ld_data2", 32'(wr_data[b_wr+2]), 32'h33);
    chk("ld_size0", 32'(wr_size[b_wr]), 8);
    chk("ld_size2", 32'(wr_size[b_wr+2]), 8);
    chk("ld_start_cnt", start_cnt - b_start, 1);
    chk("ld_done_cnt", done_cnt - b_done, 1);

    // empty run, go issued in the cycle right after done
    snap();
    do_go(7'h00, 7'h00, 8'd0, 8'd0);
    chk("e_start_lat", 32'(o_start_port), 1);
    pulse_done(4);
    chk("e_done_lat", 32'(o_done), 1);
    chk("e_tmo", 32'(o_timeout), 0);
    wait_done();
    chk("e_start_cnt", start_cnt - b_start, 1);
    chk("e_wr_cnt", wr_cnt - b_wr, 0);
    chk("e_oe_cnt", oe_cnt - b_oe, 0);
    chk("e_done_cnt", done_cnt - b_done, 1);

    // two-word readback with backpressure
    snap();
    mem[7'h10] = 8'hA5; mem[7'h11] = 8'h5A; rdy_dly = 2;
    do_go(7'h00, 7'h10, 8'd0, 8'd2);
    wait_start();
    pulse_done(1);
    serve_reads(2, 3);
    wait_done();
    chk("rb_word0", 32'(rb_got[0]), 32'hA5);
    chk("rb_word1", 32'(rb_got[1]), 32'h5A);
    chk("rb_oe_cnt", oe_cnt - b_oe, 2);
    chk("rb_raddr0", 32'(rd_addr[b_rd]), 32'h10);
    chk("rb_raddr1", 32'(rd_addr[b_rd+1]), 32'h11);
    chk("rb_done_cnt", done_cnt - b_done, 1);
    chk("rb_wr_cnt", wr_cnt - b_wr, 0);

    // done_port during START and go during RUN are both ignored
    snap();
    do_go(7'h20, 7'h00, 8'd0, 8'd0);
    wait_start();
    i_done_port = 1'b1;
    step();
    i_done_port = 1'b0;
    repeat (3) step();
    chk("ig_busy", 32'(o_busy), 1);
    chk("ig_no_done", done_cnt - b_done, 0);
    i_go = 1'b1; i_load_len = 8'd5;
    step();
    i_go = 1'b0;
    repeat (2) step();
    chk("ig_ldr", 32'(o_ld_ready), 0);
    pulse_done(0);
    wait_done();
    repeat (5) step();
    chk("ig_done_cnt", done_cnt - b_done, 1);
    chk("ig_start_cnt", start_cnt - b_start, 1);
    chk("ig_wr_cnt", wr_cnt - b_wr, 0);

`ifdef SEQ_TIMEOUT_EN
    // watchdog expiry: FINISH follows the tenth RUN cycle, readback skipped
    snap();
    do_go(7'h00, 7'h30, 8'd0, 8'd2);
    wait_start();
    wait_done();
    chk("to_latency", done_cyc - start_cyc, TMO + 1);
    chk("to_flag_at_done", 32'(done_tmo), 1);
    chk("to_oe_cnt", oe_cnt - b_oe, 0);
    repeat (2) step();
    chk("to_held", 32'(o_timeout), 1);
    do_go(7'h00, 7'h00, 8'd0, 8'd0);
    chk("to_clear", 32'(o_timeout), 0);
    pulse_done(1);
    wait_done();
`else
    // without the watchdog RUN waits for done_port indefinitely
    snap();
    do_go(7'h00, 7'h00, 8'd0, 8'd0);
    wait_start();
    repeat (40) step();
    chk("nt_busy", 32'(o_busy), 1);
    chk("nt_no_done", done_cnt - b_done, 0);
    chk("nt_tmo", 32'(o_timeout), 0);
    pulse_done(0);
    wait_done();
    chk("nt_tmo_end", 32'(o_timeout), 0);
`endif

    // asynchronous reset while waiting for read data
    snap();
    rdy_dly = 6;
    do_go(7'h00, 7'h40, 8'd0, 8'd1);
    wait_start();
    pulse_done(1);
    step();
    step();
    chk("rw_busy_pre", 32'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(o_busy), 0);
    chk("ar_rbv", 32'(o_rb_valid), 0);
    chk("ar_rbdata", 32'(o_rb_data), 0);
    chk("ar_start", 32'(o_start_port), 0);
    chk("ar_oe", 32'(bus.S_oe_ram), 0);
    chk("ar_addr", 32'(bus.S_addr_ram), 0);
    step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("ar_no_done", done_cnt - b_done, 0);
    chk("ar_rbv_after", 32'(o_rb_valid), 0);

    snap();
    ld_words[0] = 8'h44;
    do_go(7'h05, 7'h00, 8'd1, 8'd0);
    feed_load(1);
    wait_start();
    pulse_done(1);
    wait_done();
    chk("pr_wr_cnt", wr_cnt - b_wr, 1);
    chk("pr_addr", 32'(wr_addr[b_wr]), 32'h05);
    chk("pr_data", 32'(wr_data[b_wr]), 32'h44);
    chk("pr_done_cnt", done_cnt - b_done, 1);

    chk("bus_idle_zero", spur_cnt, 0);
    chk("ch1_zero", ch1_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
